axi4_burst_splitter: RTL

Upstream stage of the AXI4 command driver. Accepts one transfer request (start address plus total beat count) and splits it into a train of AXI4 INCR burst commands. Each burst is no longer than `MaxBurstBeats` and, optionally, never crosses a 4 KB boundary. Its `DST*` outputs connect one-to-one to the command driver's `SRCADDR`, `SRCLEN`, `SRCVALID`, `SRCREADY` and `SRCFLUSH` inputs.

---
 rtl/axi4_burst_splitter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/axi4_burst_splitter.sv
// axi4_burst_splitter: splits one (address, beat count) request into a train
// of AXI4 INCR burst commands of at most MaxBurstBeats beats each.
// Optional macro AXI4_BURST_BOUNDARY_SPLIT_EN: additionally cut bursts so that
// none crosses a 4 KB boundary.
module axi4_burst_splitter #(
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned LengthWidth   = 16,
  parameter int unsigned MaxBurstBeats = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [AddressWidth-1:0] REQADDR,
  input  logic [LengthWidth-1:0]  REQLEN,
  input  logic                    REQVALID,
  output logic                    REQREADY,
  output logic [AddressWidth-1:0] DSTADDR,
  output logic [7:0]              DSTLEN,
  output logic                    DSTVALID,
  input  logic                    DSTREADY,
  output logic                    DSTFLUSH,
  output logic                    BUSY,
  output logic                    DONE
);

  localparam int unsigned BytesPerBeat = DataWidth / 8;
  localparam int unsigned ByteShift    = $clog2(BytesPerBeat);
  localparam int unsigned BurstWidth   = 9;
  localparam logic [AddressWidth-1:0] AddrMask = ~AddressWidth'(BytesPerBeat - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DONE} state_t;

  state_t                  state_q, state_n;
  logic [AddressWidth-1:0] r_addr;
  logic [LengthWidth-1:0]  r_remain;
  logic [BurstWidth-1:0]   r_burst;
  logic [BurstWidth-1:0]   burst_c;
  logic [LengthWidth-1:0]  remain_next_c;
  logic [31:0]             cap_c;
  logic                    req_fire_c, dst_fire_c;
  logic                    req_ready_n, dst_valid_n, dst_flush_n, busy_n, done_n;
`ifdef AXI4_BURST_BOUNDARY_SPLIT_EN
  logic [12:0]             to_bound_c;
`endif

  assign req_fire_c    = (state_q == S_IDLE) && REQVALID && REQREADY;
  assign dst_fire_c    = (state_q == S_ISSUE) && DSTVALID && DSTREADY;
  assign remain_next_c = r_remain - LengthWidth'(r_burst);
  assign DSTADDR       = r_addr;

  // Next burst length: min of remaining beats, max burst and (optionally) beats to 4 KB.
  always_comb begin
    cap_c = (32'(r_remain) < 32'(MaxBurstBeats)) ? 32'(r_remain) : 32'(MaxBurstBeats);
`ifdef AXI4_BURST_BOUNDARY_SPLIT_EN
    to_bound_c = (13'd4096 - {1'b0, r_addr[11:0]}) >> ByteShift;
    if (32'(to_bound_c) < cap_c) cap_c = 32'(to_bound_c);
`endif
    burst_c = BurstWidth'(cap_c);
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= S_IDLE;
    else          state_q <= state_n;
  end

  // Next state and next registered output values.
  always_comb begin
    state_n     = state_q;
    req_ready_n = 1'b0;
    dst_valid_n = 1'b0;
    dst_flush_n = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    case (state_q)
      S_IDLE:  if (req_fire_c) state_n = (REQLEN != '0) ? S_CALC : S_DONE;
      S_CALC:  state_n = S_ISSUE;
      S_ISSUE: if (dst_fire_c) state_n = (remain_next_c == '0) ? S_DONE : S_CALC;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    req_ready_n = (state_n == S_IDLE);
    dst_valid_n = (state_n == S_ISSUE);
    dst_flush_n = (state_n == S_CALC) || (state_n == S_ISSUE);
    busy_n      = (state_n != S_IDLE);
    done_n      = (state_n == S_DONE);
  end

  // Control outputs registered from the next state so nothing is combinational.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      REQREADY <= 1'b0;
      DSTVALID <= 1'b0;
      DSTFLUSH <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      REQREADY <= req_ready_n;
      DSTVALID <= dst_valid_n;
      DSTFLUSH <= dst_flush_n;
      BUSY     <= busy_n;
      DONE     <= done_n;
    end
  end

  // Address / remaining-beat bookkeeping and burst length register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_addr   <= '0;
      r_remain <= '0;
      r_burst  <= '0;
      DSTLEN   <= '0;
    end else begin
      if (req_fire_c) begin
        r_addr   <= REQADDR & AddrMask;
        r_remain <= REQLEN;
      end
      if (state_q == S_CALC) begin
        r_burst <= burst_c;
        DSTLEN  <= 8'(burst_c - BurstWidth'(1));
      end
      if (dst_fire_c) begin
        r_addr   <= r_addr + (AddressWidth'(r_burst) << ByteShift);
        r_remain <= remain_next_c;
      end
    end
  end

endmodule
